bus_gnrtr_n_rbtr: RTL and testbench

- Shared-bus generator and arbiter connecting `drvrs` device ports, each backed by an external FIFO.
- Grants devices with pending data in round-robin order, pops one packet from the winner and routes it by destination ID in the packet MSBs.
- Delivery goes to one device or, for broadcast, to all other devices.
- Sits between the per-device FIFO/driver models and the rest of the bus fabric.

---
 rtl/bus_gnrtr_n_rbtr.sv | 136 +++++++++++++
 tb/tb_bus_gnrtr_n_rbtr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_gnrtr_n_rbtr.sv
// Shared-bus generator/arbiter: round-robin grant, pop one packet, route by dest ID.
// Optional BUS_DROP_CNT_EN adds a saturating count of dropped packets.
module bus_gnrtr_n_rbtr #(
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push
`ifdef BUS_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int IW = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PUSH
    } state_t;

    state_t             state;
    logic [IW-1:0]      grant;
    logic [IW-1:0]      last;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      cand;
    logic               found;
    int                 idx;
    logic [pckg_sz-1:0] pkt;
    logic [pckg_sz-1:0] lane;
    logic [pckg_sz-1:0] lanes [drvrs];
    logic [7:0]         dest;
    logic [drvrs-1:0]   route;
    logic [drvrs-1:0]   one_hot;

    always_comb begin
        for (int i = 0; i < drvrs; i++) begin
            lanes[i] = D_pop[i*pckg_sz +: pckg_sz];
        end
    end

    assign lane    = lanes[grant];
    assign dest    = lane[pckg_sz-1 -: 8];
    assign one_hot = {{(drvrs-1){1'b0}}, 1'b1} << winner;
    assign D_push  = {drvrs{pkt}};

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        cand   = '0;
        for (int k = 1; k <= drvrs; k++) begin
            idx  = (int'(last) + k) % drvrs;
            cand = IW'(idx);
            if (!found && pndng[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Broadcast skips the sender; unknown IDs leave route empty and are dropped.
    always_comb begin
        route = '0;
        for (int i = 0; i < drvrs; i++) begin
            if (dest == broadcast) begin
                route[i] = (i != int'(grant));
            end else begin
                route[i] = (int'(dest) == i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= IW'(drvrs-1);
            pkt   <= '0;
            pop   <= '0;
            push  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    push <= '0;
                    if (found) begin
                        grant <= winner;
                        last  <= winner;
                        pop   <= one_hot;
                        state <= POP;
                    end
                end
                POP: begin
                    pop   <= '0;
                    pkt   <= lane;
                    push  <= route;
                    state <= PUSH;
                end
                PUSH: begin
                    push  <= '0;
                    state <= IDLE;
                end
                default: begin
                    pop   <= '0;
                    push  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_DROP_CNT_EN
    logic [7:0] pkt_id;
    logic       pkt_drop;

    assign pkt_id   = pkt[pckg_sz-1 -: 8];
    assign pkt_drop = (pkt_id != broadcast) && (int'(pkt_id) >= drvrs);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (state == PUSH && pkt_drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_gnrtr_n_rbtr.sv
// Bench for bus_gnrtr_n_rbtr: per-device FIFO queues feed the DUT and a
// transaction-level model predicts pop/push/D_push each cycle.
module tb_bus_gnrtr_n_rbtr;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   pndng;
    logic [N*W-1:0] D_pop;
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [N*W-1:0] D_push;
`ifdef BUS_DROP_CNT_EN
    logic [15:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    bus_gnrtr_n_rbtr #(
        .drvrs    (N),
        .pckg_sz  (W),
        .broadcast(8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pndng (pndng),
        .D_pop (D_pop),
        .pop   (pop),
        .push  (push),
        .D_push(D_push)
`ifdef BUS_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0] pop;
        logic [N-1:0] push;
        bit           ld;
        logic [W-1:0] data;
        int           dev;
        bit           drop;
    } exp_t;

    exp_t         sched[$];
    logic [W-1:0] q[N][$];
    logic [N-1:0] pop_log[$];
    logic [W-1:0] exp_dpush = '0;
    int           last_m    = N-1;
    int           drop_m    = 0;
    bit           deq_vld   = 0;
    int           deq_dev   = 0;
    int           add_pct   = 0;

    // Winner is the requester at the smallest forward distance from the last grant.
    function automatic int pick(input logic [N-1:0] req, input int lst);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            d = (i - lst - 1 + N) % N;
            if (req[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    function automatic logic [W-1:0] rand_pkt();
        int         r;
        logic [7:0] id;
        r = $urandom_range(0, 9);
        if (r < 4)      id = 8'($urandom_range(0, N-1));
        else if (r < 6) id = 8'hFF;
        else            id = 8'($urandom_range(N, 254));
        return {id, 8'($urandom)};
    endfunction

    function automatic int qtot();
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += q[i].size();
        return s;
    endfunction

    task automatic step(input bit rst_nxt);
        exp_t       cur;
        exp_t       tp;
        exp_t       tu;
        bit         cur_idle;
        int         g;
        logic [7:0] id;
        @(negedge clk);
        if (deq_vld) begin
            if (q[deq_dev].size() > 0) void'(q[deq_dev].pop_front());
            deq_vld = 0;
        end
        cur      = '{default: 0};
        cur_idle = (sched.size() == 0);
        if (!cur_idle) cur = sched.pop_front();
        if (cur.ld) exp_dpush = cur.data;
        check("pop", 64'(pop), 64'(cur.pop));
        check("push", 64'(push), 64'(cur.push));
        check("d_push", 64'(D_push), 64'({N{exp_dpush}}));
`ifdef BUS_DROP_CNT_EN
        check("drop_cnt", 64'(drop_cnt), 64'(drop_m));
`endif
        if (pop != 0) pop_log.push_back(pop);
        if (cur.pop != 0) begin
            deq_vld = 1;
            deq_dev = cur.dev;
        end
        if (cur.drop && drop_m < 16'hFFFF) drop_m++;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() < 4 && $urandom_range(0, 99) < add_pct)
                q[i].push_back(rand_pkt());
        end
        for (int i = 0; i < N; i++) begin
            pndng[i]      = (q[i].size() != 0);
            D_pop[i*W +: W] = (q[i].size() != 0) ? q[i][0] : 16'($urandom);
        end
        reset = rst_nxt;
        if (rst_nxt) begin
            sched.delete();
            exp_dpush = '0;
            last_m    = N-1;
            drop_m    = 0;
        end else if (cur_idle && pndng != 0) begin
            g       = pick(pndng, last_m);
            last_m  = g;
            tp      = '{default: 0};
            tp.pop  = N'(1) << g;
            tp.dev  = g;
            tu      = '{default: 0};
            tu.ld   = 1;
            tu.data = q[g][0];
            id      = tu.data[W-1 -: 8];
            if (id == 8'hFF)  tu.push = ~(N'(1) << g);
            else if (id < N)  tu.push = N'(1) << id;
            else              tu.drop = 1;
            sched.push_back(tp);
            sched.push_back(tu);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sched.size() != 0 || qtot() != 0) && n < 200) begin
            step(0);
            n++;
        end
        check("drain_timeout", 64'(n >= 200), 64'(0));
        step(0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        for (int i = 0; i < N; i++) q[i].push_back({8'((i + 1) % N), 8'(i)});
        repeat (5) step(1);

        pop_log.delete();
        repeat (12) step(0);
        check("rr_count", 64'(pop_log.size()), 64'(4));
        for (int i = 0; i < N; i++) begin
            if (i < pop_log.size())
                check("rr_grant", 64'(pop_log[i]), 64'(N'(1) << i));
        end
        drain();

        q[1].push_back(16'h02AB);
        drain();
        q[3].push_back(16'hFF55);
        drain();
        q[0].push_back(16'h0711);
        drain();

        for (int i = 0; i < N; i++) q[i].push_back({8'(i), 8'h3C});
        n = 0;
        while (sched.size() != 2 && n < 20) begin
            step(0);
            n++;
        end
        check("mid_rst_wait", 64'(n >= 20), 64'(0));
        step(1);
        pop_log.delete();
        drain();
        check("rst_ptr", 64'(pop_log.size() > 0 ? pop_log[0] : '0), 64'(1));

        add_pct = 30;
        for (int c = 0; c < 3000; c++) step($urandom_range(0, 99) == 0);
        add_pct = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
